// File: rtl/bram_multi_reader.sv
// Round-robin read front-end that shares one single-port BRAM among N_CH pixel streams.
// Each channel fetches one word at a time, buffers it, and hands it out lowest pixel first.
module bram_multi_reader #(
  parameter int N_CH            = 2,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int PIX_WIDTH       = 16,
  localparam int PIX_PER_WORD   = BRAM_DATA_WIDTH / PIX_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [N_CH-1:0]                 i_start,
  input  logic [N_CH*ADDRESS_WIDTH-1:0]   i_base_addr,
  input  logic [N_CH*ADDRESS_WIDTH-1:0]   i_num_words,
  input  logic [N_CH-1:0]                 i_rd_en,
  output logic [N_CH-1:0]                 o_rd_valid,
  output logic [N_CH*PIX_WIDTH-1:0]       o_rd_data,
  output logic [N_CH-1:0]                 o_busy,
  output logic [N_CH-1:0]                 o_done,
  output logic [ADDRESS_WIDTH-1:0]        bram_addr,
  output logic                            bram_en,
  output logic                            bram_we,
  input  logic [BRAM_DATA_WIDTH-1:0]      bram_data_out
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t                     state     [N_CH];
  logic [ADDRESS_WIDTH-1:0]   addr      [N_CH];
  logic [ADDRESS_WIDTH-1:0]   remaining [N_CH];
  logic [BRAM_DATA_WIDTH-1:0] buffer    [N_CH];
  logic [IW-1:0]              idx       [N_CH];
  logic [CW-1:0]              rr_ptr;
  logic                       grant_vld;
  logic [CW-1:0]              grant;

  // First FETCH requester found scanning upward from the round-robin pointer.
  always_comb begin
    int ch;
    ch        = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch = (int'(rr_ptr) + k) % N_CH;
      if (!grant_vld && state[ch] == FETCH) begin
        grant_vld = 1'b1;
        grant     = CW'(ch);
      end
    end
  end

  assign bram_en   = grant_vld;
  assign bram_addr = grant_vld ? addr[grant] : '0;
  assign bram_we   = 1'b0;

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign o_rd_valid[g] = (state[g] == HOLD);
    assign o_busy[g]     = (state[g] != IDLE);
    assign o_rd_data[g*PIX_WIDTH +: PIX_WIDTH] =
      o_rd_valid[g] ? buffer[g][idx[g]*PIX_WIDTH +: PIX_WIDTH] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
      o_done <= '0;
      for (int c = 0; c < N_CH; c++) begin
        state[c]     <= IDLE;
        addr[c]      <= '0;
        remaining[c] <= '0;
        buffer[c]    <= '0;
        idx[c]       <= '0;
      end
    end else begin
      if (grant_vld)
        rr_ptr <= CW'((int'(grant) + 1) % N_CH);
      for (int c = 0; c < N_CH; c++) begin
        o_done[c] <= 1'b0;
        case (state[c])
          IDLE: begin
            if (i_start[c]) begin
              if (i_num_words[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] == '0) begin
                o_done[c] <= 1'b1;
              end else begin
                state[c]     <= FETCH;
                addr[c]      <= i_base_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                remaining[c] <= i_num_words[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
              end
            end
          end
          FETCH: begin
            if (grant_vld && grant == CW'(c)) begin
              addr[c]      <= addr[c] + 1'b1;
              remaining[c] <= remaining[c] - 1'b1;
              state[c]     <= WAIT;
            end
          end
          WAIT: begin
            buffer[c] <= bram_data_out;
            idx[c]    <= '0;
            state[c]  <= HOLD;
          end
          HOLD: begin
            if (i_rd_en[c]) begin
              if (idx[c] == IW'(PIX_PER_WORD - 1)) begin
                if (remaining[c] != '0) begin
                  state[c] <= FETCH;
                end else begin
                  state[c]  <= IDLE;
                  o_done[c] <= 1'b1;
                end
              end else begin
                idx[c] <= idx[c] + 1'b1;
              end
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_multi_reader.sv
// Bench for bram_multi_reader: directed timing checks plus a random run against a
// pixel-stream scoreboard built from BRAM contents, base and word count.
module tb_bram_multi_reader;
  localparam int N  = 2;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int PW = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [N-1:0]      i_start;
  logic [N*AW-1:0]   i_base_addr;
  logic [N*AW-1:0]   i_num_words;
  logic [N-1:0]      i_rd_en;
  logic [N-1:0]      o_rd_valid;
  logic [N*PW-1:0]   o_rd_data;
  logic [N-1:0]      o_busy;
  logic [N-1:0]      o_done;
  logic [AW-1:0]     bram_addr;
  logic              bram_en;
  logic              bram_we;
  logic [DW-1:0]     bram_data_out = '0;

  always #5 i_clk = ~i_clk;

  bram_multi_reader #(.N_CH(N), .ADDRESS_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .PIX_WIDTH(PW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_words(i_num_words), .i_rd_en(i_rd_en), .o_rd_valid(o_rd_valid),
    .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done), .bram_addr(bram_addr),
    .bram_en(bram_en), .bram_we(bram_we), .bram_data_out(bram_data_out)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge i_clk) if (bram_en) bram_data_out <= mem[bram_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each channel's remaining pixel stream; a channel is busy while it is non-empty.
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  logic [N-1:0]  done_next = '0;
  int            done_cnt [N];

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int c, input logic [PW-1:0] v);
    if (c == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int c, output logic [PW-1:0] v);
    if (c == 0) v = q0.pop_front(); else v = q1.pop_front();
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    done_next = '0;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      check("we_zero", bram_we, 0);
      for (int c = 0; c < N; c++) begin
        logic        nd;
        logic        was_empty;
        logic [PW-1:0] pix;
        logic [AW-1:0] base;
        logic [AW-1:0] cnt;
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        nd = 1'b0;
        check("busy", o_busy[c], qsize(c) != 0);
        check("done", o_done[c], done_next[c]);
        if (o_done[c]) done_cnt[c]++;
        was_empty = (qsize(c) == 0);
        if (was_empty) begin
          check("valid_idle", o_rd_valid[c], 0);
        end else if (o_rd_valid[c] && i_rd_en[c]) begin
          qpop(c, pix);
          check("pixel", o_rd_data[c*PW +: PW], pix);
          if (qsize(c) == 0) nd = 1'b1;
        end
        if (i_start[c] && was_empty) begin
          base = i_base_addr[c*AW +: AW];
          cnt  = i_num_words[c*AW +: AW];
          if (cnt == 0) nd = 1'b1;
          for (int w = 0; w < int'(cnt); w++) begin
            a    = base + AW'(w);
            word = mem[a];
            for (int p = 0; p < DW/PW; p++) qpush(c, word[p*PW +: PW]);
          end
        end
        done_next[c] = nd;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents start for one cycle; returns 1 time unit after the sampling edge.
  task automatic start_pair(input logic [N-1:0] m, input logic [AW-1:0] b0, input logic [AW-1:0] c0,
                            input logic [AW-1:0] b1, input logic [AW-1:0] c1);
    tick();
    i_start     = m;
    i_base_addr = {b1, b0};
    i_num_words = {c1, c0};
    tick();
    i_start = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int c, input string tag);
    int n = 0;
    while (!o_rd_valid[c] && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, o_rd_valid[c], 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy != '0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    check(tag, o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_rd_valid, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_en"},    bram_en, 0);
    check({tag, "_we"},    bram_we, 0);
    check({tag, "_addr"},  bram_addr, 0);
    check({tag, "_data"},  o_rd_data, 0);
  endtask

  initial begin
    int d0;
    int n;
    logic [PW-1:0] held;
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    mem[5]    = 32'hBBBBAAAA;
    mem[6]    = 32'hDDDDCCCC;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    i_rst_n     = 1'b0;
    i_start     = '0;
    i_base_addr = '0;
    i_num_words = '0;
    i_rd_en     = '0;
    #1;
    check_all_zero("reset");
    do_reset();

    // Single channel, first valid two cycles after the start edge.
    i_rd_en = 2'b11;
    start_pair(2'b01, 13'd5, 13'd2, 13'd0, 13'd0);
    @(negedge i_clk);
    check("t1_en", bram_en, 1);
    check("t1_addr", bram_addr, 5);
    check("t1_v_e0", o_rd_valid[0], 0);
    @(negedge i_clk);
    check("t1_v_e1", o_rd_valid[0], 0);
    @(negedge i_clk);
    check("t1_v_e2", o_rd_valid[0], 1);
    check("t1_pix0", o_rd_data[PW-1:0], 16'hAAAA);
    d0 = done_cnt[0];
    wait_idle("t1_idle");
    check("t1_done_cnt", done_cnt[0] - d0, 1);

    // Contention from a fresh pointer.
    do_reset();
    start_pair(2'b11, 13'd0, 13'd1, 13'd100, 13'd1);
    @(negedge i_clk);
    check("t2_en0", bram_en, 1);
    check("t2_addr0", bram_addr, 0);
    @(negedge i_clk);
    check("t2_en1", bram_en, 1);
    check("t2_addr1", bram_addr, 100);
    @(negedge i_clk);
    check("t2_valid_e2", o_rd_valid, 2'b01);
    @(negedge i_clk);
    check("t2_valid1_e3", o_rd_valid[1], 1);
    wait_idle("t2_idle");

    // Backpressure mid-word.
    i_rd_en = 2'b00;
    start_pair(2'b01, 13'd10, 13'd2, 13'd0, 13'd0);
    wait_valid(0, "t3_first_valid");
    tick();
    i_rd_en[0] = 1'b1;
    tick();
    i_rd_en[0] = 1'b0;
    held = mem[10][31:16];
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("t3_hold_valid", o_rd_valid[0], 1);
      check("t3_hold_data", o_rd_data[PW-1:0], held);
      check("t3_hold_en", bram_en, 0);
    end
    i_rd_en = 2'b11;
    wait_idle("t3_idle");

    // Zero count, then a restart while busy.
    start_pair(2'b10, 13'd0, 13'd0, 13'd0, 13'd0);
    @(negedge i_clk);
    check("t4_zero_done", o_done[1], 1);
    check("t4_zero_busy", o_busy[1], 0);
    @(negedge i_clk);
    check("t4_zero_done_end", o_done[1], 0);
    d0 = done_cnt[0];
    start_pair(2'b01, 13'd20, 13'd1, 13'd0, 13'd0);
    start_pair(2'b01, 13'd300, 13'd3, 13'd0, 13'd0);
    wait_idle("t4_idle");
    check("t4_done_cnt", done_cnt[0] - d0, 1);

    // Address wrap.
    start_pair(2'b01, 13'h1FFF, 13'd2, 13'd0, 13'd0);
    @(negedge i_clk);
    check("t5_addr_hi", bram_addr, 13'h1FFF);
    @(negedge i_clk);
    n = 0;
    while (!bram_en && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("t5_second_en", bram_en, 1);
    check("t5_addr_wrap", bram_addr, 0);
    wait_idle("t5_idle");

    // Reset while channel 1 waits on BRAM data.
    start_pair(2'b10, 13'd0, 13'd0, 13'd40, 13'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t6_busy_pre", o_busy[1], 1);
    i_rst_n = 1'b0;
    model_clear();
    #1;
    check_all_zero("t6_async");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("t6_no_stale", o_rd_valid, 0);
    end
    start_pair(2'b10, 13'd0, 13'd0, 13'd41, 13'd1);
    wait_valid(1, "t6_fresh_valid");
    wait_idle("t6_idle");

    // Random starts and random backpressure against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      tick();
      i_rd_en = 2'($urandom);
      for (int c = 0; c < N; c++) begin
        i_start[c] = ($urandom_range(0, 7) == 0);
        i_base_addr[c*AW +: AW] = AW'($urandom);
        i_num_words[c*AW +: AW] = AW'($urandom_range(0, 3));
      end
    end
    tick();
    i_start = '0;
    i_rd_en = 2'b11;
    wait_idle("rand_idle");
    check("rand_q0_empty", qsize(0), 0);
    check("rand_q1_empty", qsize(1), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
